pixel_compositor: RTL

Final pixel stage between the sprite layers (bee, hive, enemies, background) and the Basys 3 VGA connector. Each cycle it selects the highest-priority opaque layer's 8-bit colour index and maps it through a 256-entry palette to 12-bit RGB. It re-times hsync/vsync/de to match the sprite and palette pipeline, and applies a frame-counted background flash on request. Runs entirely in the 25.2 MHz pixel domain.

---
 rtl/pixel_pkg.sv | 35 +++
 rtl/palette_rom.sv | 18 +
 rtl/pixel_compositor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared pixel-domain constants and palette contents.
// Used by the compositor, palette ROM and timing generator.
package pixel_pkg;

  localparam int PIX_W = 12;
  localparam int IDX_W = 8;

  localparam logic [IDX_W-1:0] DEF_TRANSP_IDX = 8'h00;

  localparam PAL_FILE = "palette.mem";

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  // Fixed game colours; remaining entries form a smooth ramp.
  function automatic logic [PIX_W-1:0] pal_entry(
    input logic [IDX_W-1:0] i
  );
    case (i)
      8'h00:   return 12'h000;
      8'h02:   return 12'h00F;
      8'h05:   return 12'hF80;
      8'h07:   return 12'h0F0;
      8'hFF:   return 12'hFFF;
      default: return {i[3:0], i[7:4], i[3:0] ^ i[7:4]};
    endcase
  endfunction

endpackage

// File: rtl/palette_rom.sv
// 256x12 palette ROM, one read port.
// Registered read so the table maps onto block RAM.
module palette_rom
  import pixel_pkg::*;
(
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] addr,
  output logic [PIX_W-1:0] data
);

  // Registered lookup; only the output register is reset.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) data <= '0;
    else        data <= pal_entry(addr);
  end

endmodule

// File: rtl/pixel_compositor.sv
// Layer priority mux, palette lookup and sync re-timing.
// Also owns the frame-counted background flash.
module pixel_compositor
  import pixel_pkg::*;
#(
  parameter int               NUM_LAYERS   = 4,
  parameter int               SPRITE_LAT   = 2,
  parameter logic [IDX_W-1:0] TRANSP_IDX   = DEF_TRANSP_IDX,
  parameter logic             SYNC_ACTIVE  = 1'b0,
  parameter logic [7:0]       FLASH_FRAMES = 8'd8,
  parameter logic [IDX_W-1:0] FLASH_IDX    = 8'hFF
) (
  input  logic                        clk_pix,
  input  logic                        rst_n,
  input  logic                        de,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic [NUM_LAYERS-1:0]       layer_on,
  input  logic [IDX_W*NUM_LAYERS-1:0] layer_idx,
  input  logic [IDX_W-1:0]            bg_idx,
  input  logic                        flash_req,
  output logic [3:0]                  vga_r,
  output logic [3:0]                  vga_g,
  output logic [3:0]                  vga_b,
  output logic                        vga_hs,
  output logic                        vga_vs,
  output logic                        flashing
);

  localparam int DLY = SPRITE_LAT + 3;

  // The RGB register acts as the final de stage.
  logic [DLY-2:0]   de_d;
  logic [DLY-1:0]   hs_d;
  logic [DLY-1:0]   vs_d;
  logic             vs_prev;
  logic             frame_tick;
  logic [7:0]       flash_cnt;
  logic [7:0]       cnt_nxt;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] s1_idx;
  logic [PIX_W-1:0] pal_data;
  logic [PIX_W-1:0] rgb;

  // Timing delay lines.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      de_d <= '0;
      hs_d <= {DLY{~SYNC_ACTIVE}};
      vs_d <= {DLY{~SYNC_ACTIVE}};
    end else begin
      de_d <= {de_d[DLY-3:0], de};
      hs_d <= {hs_d[DLY-2:0], hsync};
      vs_d <= {vs_d[DLY-2:0], vsync};
    end
  end

  // Previous sprite-aligned vsync for edge detect.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) vs_prev <= ~SYNC_ACTIVE;
    else        vs_prev <= vs_d[SPRITE_LAT-1];
  end

  assign frame_tick = (vs_d[SPRITE_LAT-1] == SYNC_ACTIVE)
                   && (vs_prev != SYNC_ACTIVE);

  // Flash count: a request reloads, ticks count down.
  always_comb begin
    cnt_nxt = flash_cnt;
    if (flash_req)
      cnt_nxt = FLASH_FRAMES;
    else if (frame_tick && flash_cnt != 8'd0)
      cnt_nxt = flash_cnt - 8'd1;
  end

  // Flash counter and its status flag.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt <= '0;
      flashing  <= 1'b0;
    end else begin
      flash_cnt <= cnt_nxt;
      flashing  <= (cnt_nxt != 8'd0);
    end
  end

  // Highest-priority opaque layer, else background.
  always_comb begin
    logic hit;
    hit     = 1'b0;
    sel_idx = (flash_cnt != 8'd0) ? FLASH_IDX : bg_idx;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (!hit && layer_on[k]
          && layer_idx[IDX_W*k +: IDX_W] != TRANSP_IDX) begin
        hit     = 1'b1;
        sel_idx = layer_idx[IDX_W*k +: IDX_W];
      end
    end
  end

  // S1: selected colour index.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) s1_idx <= '0;
    else        s1_idx <= sel_idx;
  end

  palette_rom u_pal (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .addr    (s1_idx),
    .data    (pal_data)
  );

  // S3: blank to black outside the active area.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n)            rgb <= '0;
    else if (de_d[DLY-2])  rgb <= pal_data;
    else                   rgb <= '0;
  end

  assign vga_r  = rgb[11:8];
  assign vga_g  = rgb[7:4];
  assign vga_b  = rgb[3:0];
  assign vga_hs = hs_d[DLY-1];
  assign vga_vs = vs_d[DLY-1];

endmodule
